// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for a stable synchronised lock, then releases core_reset_n.
// All outputs registered; pll_locked reaches the FSM through a 2-flop synchroniser.
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 1000000,
  parameter int STABLE_CYCLES = 4096,
  parameter int CNT_W         = 24,
  parameter int RETRY_W       = 8
) (
  input  logic               clk_74a,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               soft_reset_req,
  input  logic               clear_status,
  output logic               pll_rst,
  output logic               core_reset_n,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [1:0]         seq_state
);

  typedef enum logic [1:0] {
    S_PLL_RESET = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               locked_meta;
  logic               locked_s;
  logic               timeout_evt;
  logic               loss_evt;
  logic               pll_rst_nxt;
  logic               core_reset_n_nxt;
  logic               lock_lost_nxt;
  logic [RETRY_W-1:0] retry_base;
  logic [RETRY_W-1:0] retry_nxt;

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      state        <= S_PLL_RESET;
      cnt          <= '0;
      locked_meta  <= 1'b0;
      locked_s     <= 1'b0;
      pll_rst      <= 1'b1;
      core_reset_n <= 1'b0;
      lock_lost    <= 1'b0;
      retry_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      locked_meta  <= pll_locked;
      locked_s     <= locked_meta;
      pll_rst      <= pll_rst_nxt;
      core_reset_n <= core_reset_n_nxt;
      lock_lost    <= lock_lost_nxt;
      retry_cnt    <= retry_nxt;
    end
  end

  // soft_reset_req outranks lock loss and counter terminals, so neither flag moves on a soft restart.
  always_comb begin
    state_nxt   = state;
    timeout_evt = 1'b0;
    loss_evt    = 1'b0;
    if (soft_reset_req && (state != S_PLL_RESET)) begin
      state_nxt = S_PLL_RESET;
    end else begin
      case (state)
        S_PLL_RESET: begin
          if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = S_STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            state_nxt   = S_PLL_RESET;
            timeout_evt = 1'b1;
          end
        end
        S_STABLE: begin
          if (!locked_s) state_nxt = S_WAIT_LOCK;
          else if (cnt == STABLE_LAST) state_nxt = S_RUN;
        end
        S_RUN: begin
          if (!locked_s) begin
            state_nxt = S_PLL_RESET;
            loss_evt  = 1'b1;
          end
        end
        default: state_nxt = S_PLL_RESET;
      endcase
    end
    if (state_nxt != state) cnt_nxt = '0;
    else if (state == S_RUN) cnt_nxt = cnt;
    else cnt_nxt = cnt + 1'b1;
  end

  // Clear is applied first so a same-cycle set still lands.
  always_comb begin
    pll_rst_nxt      = (state_nxt == S_PLL_RESET);
    core_reset_n_nxt = (state_nxt == S_RUN);
    lock_lost_nxt    = loss_evt | (lock_lost & ~clear_status);
    retry_base       = clear_status ? '0 : retry_cnt;
    retry_nxt        = retry_base;
    if (timeout_evt && (retry_base != {RETRY_W{1'b1}})) retry_nxt = retry_base + 1'b1;
  end

  assign seq_state = state;

endmodule
